// File: rtl/bp_be_stride_table_pkg.sv
// Shared types for the back-end load stride predictor.
// Holds the config enum, vaddr width lookup and the table FSM states.
package bp_be_stride_table_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_small_cfg
  } bp_params_e;

  typedef enum logic [1:0] {
    e_reset,
    e_clear,
    e_run
  } bp_be_stride_state_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    if (cfg == e_bp_small_cfg)
      return 32;
    return 39;
  endfunction

endpackage

// File: rtl/bp_be_stride_table_entry_update.sv
// Next-state of one hit entry: stride training with hysteresis,
// confidence update and the predicted address.
module bp_be_stride_table_entry_update #(
  parameter int vaddr_width_p = 39,
  parameter int stride_width_p = 12,
  parameter int ctr_width_p = 2,
  parameter int conf_thresh_p = 2,
  parameter int prefetch_dist_p = 1
) (
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  input  logic [vaddr_width_p-1:0]  last_addr_i,
  input  logic [stride_width_p-1:0] stride_i,
  input  logic [ctr_width_p-1:0]    ctr_i,
  output logic [vaddr_width_p-1:0]  last_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [ctr_width_p-1:0]    ctr_o,
  output logic                      pred_o,
  output logic [vaddr_width_p-1:0]  pred_addr_o
);

  localparam int hi_w_lp = vaddr_width_p - stride_width_p + 1;
  localparam logic [ctr_width_p-1:0] thresh_lp =
    ctr_width_p'(conf_thresh_p);
  localparam logic [vaddr_width_p-1:0] dist_lp =
    vaddr_width_p'(prefetch_dist_p);

  logic [vaddr_width_p-1:0] diff;
  logic [vaddr_width_p-1:0] stride_sext;
  logic [hi_w_lp-1:0] diff_hi;
  logic rep;
  logic match;

  assign diff = eff_addr_i - last_addr_i;
  assign diff_hi = diff[vaddr_width_p-1:stride_width_p-1];
  // diff fits when every bit above the sign bit copies the sign
  assign rep = (&diff_hi) | ~(|diff_hi);
  assign match = rep & (diff[stride_width_p-1:0] == stride_i);

  always_comb begin
    ctr_o = ctr_i;
    stride_o = stride_i;
    if (match) begin
      if (ctr_i != {ctr_width_p{1'b1}})
        ctr_o = ctr_i + 1'b1;
    end else if (ctr_i != '0) begin
      ctr_o = ctr_i - 1'b1;
    end else begin
      stride_o = rep ? diff[stride_width_p-1:0] : '0;
    end
  end

  assign last_addr_o = eff_addr_i;
  assign pred_o = (ctr_o >= thresh_lp);
  assign stride_sext = {
    {(vaddr_width_p-stride_width_p){stride_o[stride_width_p-1]}},
    stride_o
  };
  assign pred_addr_o = eff_addr_i + stride_sext * dist_lp;

endmodule

// File: rtl/bsg_mem_1r1w_sync.sv
// One-read one-write synchronous RAM; read data is registered.
// A read of the address being written returns the old contents.
module bsg_mem_1r1w_sync #(
  parameter int width_p = 8,
  parameter int els_p = 2,
  localparam int addr_w_lp = $clog2(els_p)
) (
  input  logic                 clk_i,
  input  logic                 w_v_i,
  input  logic [addr_w_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]   w_data_i,
  input  logic                 r_v_i,
  input  logic [addr_w_lp-1:0] r_addr_i,
  output logic [width_p-1:0]   r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i)
      mem_r[w_addr_i] <= w_data_i;
    if (r_v_i)
      r_data_o <= mem_r[r_addr_i];
  end

endmodule

// File: rtl/bp_be_stride_table.sv
// Set-associative load stride predictor beside the load pipe.
// Stage 1 reads the set; stage 2 trains or allocates and predicts.
module bp_be_stride_table
  import bp_be_stride_table_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int sets_p = 64,
  parameter int ways_p = 4,
  parameter int stride_width_p = 12,
  parameter int ctr_width_p = 2,
  parameter int conf_thresh_p = 2,
  parameter int prefetch_dist_p = 1,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  output logic                      init_done_o,
  input  logic                      v_i,
  input  logic [vaddr_width_p-1:0]  pc_i,
  input  logic [vaddr_width_p-1:0]  eff_addr_i,
  output logic                      pred_v_o,
  output logic [vaddr_width_p-1:0]  pred_pc_o,
  output logic [vaddr_width_p-1:0]  pred_addr_o,
  output logic [stride_width_p-1:0] stride_o
);

  localparam int idx_w_lp = $clog2(sets_p);
  localparam int tag_w_lp = vaddr_width_p - idx_w_lp;
  localparam int ptr_w_lp = (ways_p > 1) ? $clog2(ways_p) : 1;

  typedef struct packed {
    logic                      v;
    logic [tag_w_lp-1:0]       tag;
    logic [vaddr_width_p-1:0]  last_addr;
    logic [stride_width_p-1:0] stride;
    logic [ctr_width_p-1:0]    ctr;
  } entry_s;

  typedef struct packed {
    logic [ptr_w_lp-1:0] ptr;
    entry_s [ways_p-1:0] way;
  } row_s;

  localparam int row_w_lp = $bits(row_s);

  bp_be_stride_state_e state_r, state_n;
  logic [idx_w_lp-1:0] init_cnt_r, init_cnt_n;
  logic clr_we;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= e_reset;
      init_cnt_r <= '0;
    end else begin
      state_r <= state_n;
      init_cnt_r <= init_cnt_n;
    end
  end

  always_comb begin
    state_n = state_r;
    init_cnt_n = init_cnt_r;
    clr_we = 1'b0;
    unique case (state_r)
      e_reset: begin
        state_n = e_clear;
        init_cnt_n = '0;
      end
      e_clear: begin
        clr_we = 1'b1;
        init_cnt_n = init_cnt_r + 1'b1;
        if (init_cnt_r == idx_w_lp'(sets_p-1)) begin
          state_n = e_run;
          init_cnt_n = '0;
        end
      end
      e_run: ;
      default: state_n = e_reset;
    endcase
    if (flush_i) begin
      state_n = e_clear;
      init_cnt_n = '0;
    end
  end

  assign init_done_o = (state_r == e_run);

  logic v_accept;
  logic rd_v_r;
  logic [vaddr_width_p-1:0] rd_pc_r;
  logic [vaddr_width_p-1:0] rd_addr_r;
  logic fwd_v_r;
  row_s fwd_row_r;
  row_s mem_row;
  row_s row_cur;
  row_s row_new;
  logic [row_w_lp-1:0] mem_rdata;
  logic [idx_w_lp-1:0] rd_idx;
  logic [tag_w_lp-1:0] rd_tag;
  logic s2_we;

  assign v_accept = v_i & init_done_o & ~flush_i;
  assign rd_idx = rd_pc_r[idx_w_lp-1:0];
  assign rd_tag = rd_pc_r[vaddr_width_p-1:idx_w_lp];
  assign s2_we = rd_v_r & ~flush_i & ~reset_i;

  bsg_mem_1r1w_sync #(
    .width_p(row_w_lp),
    .els_p(sets_p)
  ) mem (
    .clk_i(clk_i),
    .w_v_i(clr_we | s2_we),
    .w_addr_i(clr_we ? init_cnt_r : rd_idx),
    .w_data_i(clr_we ? '0 : row_new),
    .r_v_i(v_accept),
    .r_addr_i(pc_i[idx_w_lp-1:0]),
    .r_data_o(mem_rdata)
  );

  assign mem_row = row_s'(mem_rdata);
  // RAM holds stale data when the prior access wrote the same set
  assign row_cur = fwd_v_r ? fwd_row_r : mem_row;

  logic hit;
  logic any_inv;
  logic [ptr_w_lp-1:0] hit_way;
  logic [ptr_w_lp-1:0] inv_way;
  logic [ptr_w_lp-1:0] victim;
  logic [ptr_w_lp-1:0] ptr_next;

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = ways_p-1; w >= 0; w--) begin
      if (row_cur.way[w].v && row_cur.way[w].tag == rd_tag) begin
        hit = 1'b1;
        hit_way = ptr_w_lp'(w);
      end
      if (!row_cur.way[w].v) begin
        any_inv = 1'b1;
        inv_way = ptr_w_lp'(w);
      end
    end
  end

  assign victim = any_inv ? inv_way : row_cur.ptr;
  assign ptr_next = (ways_p > 1) ? row_cur.ptr + 1'b1 : '0;

  entry_s hit_e;
  logic [vaddr_width_p-1:0] upd_last;
  logic [vaddr_width_p-1:0] upd_paddr;
  logic [stride_width_p-1:0] upd_stride;
  logic [ctr_width_p-1:0] upd_ctr;
  logic upd_pred;

  assign hit_e = row_cur.way[hit_way];

  bp_be_stride_table_entry_update #(
    .vaddr_width_p(vaddr_width_p),
    .stride_width_p(stride_width_p),
    .ctr_width_p(ctr_width_p),
    .conf_thresh_p(conf_thresh_p),
    .prefetch_dist_p(prefetch_dist_p)
  ) upd (
    .eff_addr_i(rd_addr_r),
    .last_addr_i(hit_e.last_addr),
    .stride_i(hit_e.stride),
    .ctr_i(hit_e.ctr),
    .last_addr_o(upd_last),
    .stride_o(upd_stride),
    .ctr_o(upd_ctr),
    .pred_o(upd_pred),
    .pred_addr_o(upd_paddr)
  );

  always_comb begin
    row_new = row_cur;
    if (hit) begin
      row_new.way[hit_way].last_addr = upd_last;
      row_new.way[hit_way].stride = upd_stride;
      row_new.way[hit_way].ctr = upd_ctr;
    end else begin
      row_new.way[victim].v = 1'b1;
      row_new.way[victim].tag = rd_tag;
      row_new.way[victim].last_addr = rd_addr_r;
      row_new.way[victim].stride = '0;
      row_new.way[victim].ctr = '0;
      if (!any_inv)
        row_new.ptr = ptr_next;
    end
  end

  logic s2_pred;
  assign s2_pred = s2_we & hit & upd_pred;

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      rd_v_r <= 1'b0;
      rd_pc_r <= '0;
      rd_addr_r <= '0;
      fwd_v_r <= 1'b0;
      fwd_row_r <= '0;
    end else begin
      rd_v_r <= v_accept;
      if (v_accept) begin
        rd_pc_r <= pc_i;
        rd_addr_r <= eff_addr_i;
      end
      fwd_v_r <= v_accept & s2_we
        & (pc_i[idx_w_lp-1:0] == rd_idx);
      fwd_row_r <= row_new;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i | flush_i) begin
      pred_v_o <= 1'b0;
      pred_pc_o <= '0;
      pred_addr_o <= '0;
      stride_o <= '0;
    end else begin
      pred_v_o <= s2_pred;
      pred_pc_o <= s2_pred ? rd_pc_r : '0;
      pred_addr_o <= s2_pred ? upd_paddr : '0;
      stride_o <= s2_pred ? upd_stride : '0;
    end
  end

endmodule
